// File: rtl/rob_commit_unit_pkg.sv
// Shared constants and types for the reorder-buffer commit unit.
// Tag 0 (ZERO_ROB) means "no tag"; live entries use tags ROB_FIRST..ROB_SIZE-1.
// rob_next() is the pointer-advance rule used by every ROB pointer.
package rob_commit_unit_pkg;

  localparam int ROB_WIDTH  = 4;
  localparam int ROB_SIZE   = 1 << ROB_WIDTH;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  typedef logic [ROB_WIDTH-1:0]  rob_tag_t;
  typedef logic [REG_WIDTH-1:0]  reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam rob_tag_t ZERO_ROB  = '0;
  localparam rob_tag_t ROB_FIRST = rob_tag_t'(1);
  localparam rob_tag_t ROB_LAST  = rob_tag_t'(ROB_SIZE - 1);

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Registered commit port contents.
  typedef struct packed {
    reg_idx_t rd;
    rob_tag_t tag;
    data_t    value;
  } rob_commit_t;

  // Wrap from the last slot straight back to ROB_FIRST so a pointer never
  // lands on the reserved tag 0.
  function automatic rob_tag_t rob_next(input rob_tag_t p);
    return (p == ROB_LAST) ? ROB_FIRST : rob_tag_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/rob_commit_unit_ptr.sv
// rob_ptr: circular ROB pointer register that skips tag 0.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, loads ROB_FIRST
//   advance - step to the next slot this cycle
//   ptr     - current pointer value
module rob_ptr
  import rob_commit_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     advance,
  output rob_tag_t ptr
);

  rob_tag_t ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= ROB_FIRST;
    end else if (advance) begin
      ptr_reg <= rob_next(ptr_reg);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order reorder buffer for the Tomasulo core.
// Hands out tags at issue, captures CDB results, retires one entry per cycle
// in program order onto the register-file write port, and forwards operand
// values for busy registers.
// Ports:
//   clk, rst, ena              - clock, sync active-high reset, global enable
//   alloc_ena/alloc_rd         - issue request and its destination register
//   alloc_tag, full, empty     - next tag to hand out, occupancy flags
//   cdb_valid/cdb_tag/cdb_value- result broadcast
//   query_tag1/2 -> query_ready1/2, query_value1/2 - operand forwarding
//   commit_reg/tag/value       - registered retirement port (commit_reg 0 = no write)
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     ena,
  input  logic     alloc_ena,
  input  reg_idx_t alloc_rd,
  output rob_tag_t alloc_tag,
  output logic     full,
  output logic     empty,
  input  logic     cdb_valid,
  input  rob_tag_t cdb_tag,
  input  data_t    cdb_value,
  input  rob_tag_t query_tag1,
  input  rob_tag_t query_tag2,
  output logic     query_ready1,
  output logic     query_ready2,
  output data_t    query_value1,
  output data_t    query_value2,
  output reg_idx_t commit_reg,
  output rob_tag_t commit_tag,
  output data_t    commit_value
);

  rob_tag_t            head;
  rob_tag_t            tail;
  rob_tag_t            count_reg;
  rob_tag_t            count_next;
  logic [ROB_SIZE-1:0] valid_reg;
  logic [ROB_SIZE-1:0] valid_next;
  logic [ROB_SIZE-1:0] ready_reg;
  logic [ROB_SIZE-1:0] ready_next;
  reg_idx_t            rd_mem    [ROB_SIZE];
  data_t               value_mem [ROB_SIZE];
  rob_commit_t         commit_reg_q;

  logic alloc_fire;
  logic cdb_fire;
  logic commit_fire;

  assign full  = (count_reg == ROB_LAST);
  assign empty = (count_reg == ZERO_ROB);

  // Allocation looks only at the registered full flag, so a slot freed by a
  // commit in the same cycle is not reusable until the next cycle.
  assign alloc_fire  = ena & alloc_ena & ~full;
  // valid_reg[0] is never set, which also drops CDB writes to tag 0.
  assign cdb_fire    = ena & cdb_valid & valid_reg[cdb_tag];
  assign commit_fire = ena & valid_reg[head] & ready_reg[head];

  rob_ptr u_head_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (commit_fire),
    .ptr     (head)
  );

  rob_ptr u_tail_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (alloc_fire),
    .ptr     (tail)
  );

  assign alloc_tag = tail;

  always_comb begin
    count_next = count_reg;
    case ({alloc_fire, commit_fire})
      2'b10:   count_next = rob_tag_t'(count_reg + 1'b1);
      2'b01:   count_next = rob_tag_t'(count_reg - 1'b1);
      default: count_next = count_reg;
    endcase
  end

  // Per-entry flag updates. Allocation and commit never hit the same slot in
  // one cycle: tail == head only when empty (nothing to commit) or full (no
  // allocation). ready survives a commit and is cleared on reallocation.
  for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
    logic alloc_here;
    logic cdb_here;
    logic commit_here;

    assign alloc_here  = alloc_fire  & (tail    == rob_tag_t'(gi));
    assign cdb_here    = cdb_fire    & (cdb_tag == rob_tag_t'(gi));
    assign commit_here = commit_fire & (head    == rob_tag_t'(gi));

    assign valid_next[gi] = alloc_here ? TRUE  : (commit_here ? FALSE : valid_reg[gi]);
    assign ready_next[gi] = alloc_here ? FALSE : (cdb_here    ? TRUE  : ready_reg[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      ready_reg    <= '0;
      count_reg    <= ZERO_ROB;
      commit_reg_q <= '0;
    end else if (ena) begin
      valid_reg <= valid_next;
      ready_reg <= ready_next;
      count_reg <= count_next;
      if (commit_fire) begin
        commit_reg_q.rd    <= rd_mem[head];
        commit_reg_q.tag   <= head;
        commit_reg_q.value <= value_mem[head];
      end else begin
        // No write this cycle; tag/value keep their last committed contents.
        commit_reg_q.rd <= '0;
      end
    end
  end

  // Payload storage needs no reset: it is only read through valid/ready.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd_mem[tail] <= alloc_rd;
    end
    if (cdb_fire) begin
      value_mem[cdb_tag] <= cdb_value;
    end
  end

  assign commit_reg   = commit_reg_q.rd;
  assign commit_tag   = commit_reg_q.tag;
  assign commit_value = commit_reg_q.value;

  // Operand forwarding; a same-cycle CDB broadcast wins over stored state.
  for (genvar gi = 0; gi < 2; gi++) begin : g_query
    rob_tag_t tag;
    logic     rdy;
    data_t    val;

    assign tag = (gi == 0) ? query_tag1 : query_tag2;

    always_comb begin
      rdy = FALSE;
      val = '0;
      if (tag == ZERO_ROB) begin
        rdy = FALSE;
        val = '0;
      end else if (cdb_valid && (cdb_tag == tag)) begin
        rdy = TRUE;
        val = cdb_value;
      end else begin
        rdy = ready_reg[tag];
        val = value_mem[tag];
      end
    end
  end

  assign query_ready1 = g_query[0].rdy;
  assign query_value1 = g_query[0].val;
  assign query_ready2 = g_query[1].rdy;
  assign query_value2 = g_query[1].val;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit: directed scenarios plus a randomized run
// checked against a program-order queue model of the reorder buffer.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic     clk = 1'b0;
  logic     rst, ena, alloc_ena, cdb_valid;
  reg_idx_t alloc_rd;
  rob_tag_t alloc_tag, cdb_tag, query_tag1, query_tag2, commit_tag;
  logic     full, empty, query_ready1, query_ready2;
  data_t    cdb_value, query_value1, query_value2, commit_value;
  reg_idx_t commit_reg;

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight tags in program order plus per-tag payload.
  int          m_q[$];
  bit          m_ready [16];
  int          m_rd    [16];
  logic [31:0] m_val   [16];
  int          m_tail;
  int          e_creg, e_ctag;
  logic [31:0] e_cval;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .rst(rst), .ena(ena),
    .alloc_ena(alloc_ena), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .full(full), .empty(empty),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .commit_reg(commit_reg), .commit_tag(commit_tag), .commit_value(commit_value)
  );

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 16; i++) m_ready[i] = 1'b0;
    m_tail = 1;
    e_creg = 0; e_ctag = 0; e_cval = '0;
  endtask

  function automatic bit in_flight(int t);
    foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Applies the current inputs to the model as one clock edge would.
  task automatic model_step();
    int n;
    bit do_commit, do_cdb, do_alloc;
    if (rst) begin model_reset(); return; end
    if (!ena) return;
    n         = m_q.size();
    do_commit = (n > 0) && m_ready[m_q[0]];
    do_cdb    = cdb_valid && in_flight(int'(cdb_tag));
    do_alloc  = alloc_ena && (n != 15);
    if (do_commit) begin
      e_creg = m_rd[m_q[0]]; e_ctag = m_q[0]; e_cval = m_val[m_q[0]];
      void'(m_q.pop_front());
    end else begin
      e_creg = 0;
    end
    if (do_cdb) begin
      m_ready[cdb_tag] = 1'b1;
      m_val[cdb_tag]   = cdb_value;
    end
    if (do_alloc) begin
      m_q.push_back(m_tail);
      m_ready[m_tail] = 1'b0;
      m_rd[m_tail]    = int'(alloc_rd);
      m_tail          = (m_tail % 15) + 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; ena = 1; alloc_ena = 0; alloc_rd = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
    query_tag1 = '0; query_tag2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (alloc_tag !== 4'd1) begin errors++; $display("FAIL reset_alloc_tag got %0d want 1", alloc_tag); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (commit_reg !== 5'd0) begin errors++; $display("FAIL reset_commit_reg got %0d want 0", commit_reg); end
    checks++; if (commit_tag !== 4'd0) begin errors++; $display("FAIL reset_commit_tag got %0d want 0", commit_tag); end
    checks++; if (commit_value !== 32'd0) begin errors++; $display("FAIL reset_commit_value got %h want 0", commit_value); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    alloc_ena = 1; alloc_rd = 5'd5; tick();
    alloc_ena = 0; cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'hDEADBEEF; tick();
    cdb_valid = 0; tick();
    checks++; if (commit_reg !== 5'd5) begin errors++; $display("FAIL single_commit_reg got %0d want 5", commit_reg); end
    checks++; if (commit_tag !== 4'd1) begin errors++; $display("FAIL single_commit_tag got %0d want 1", commit_tag); end
    checks++; if (commit_value !== 32'hDEADBEEF) begin errors++; $display("FAIL single_commit_value got %h want deadbeef", commit_value); end
    tick();
    checks++; if (commit_reg !== 5'd0) begin errors++; $display("FAIL single_after_reg got %0d want 0", commit_reg); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_after_empty got %b want 1", empty); end
    $display("test_single done");
  endtask

  task automatic test_in_order();
    do_reset();
    alloc_ena = 1; alloc_rd = 5'd3; tick();
    alloc_rd = 5'd4; tick();
    alloc_ena = 0; cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'd7; tick();
    checks++; if (commit_reg !== 5'd0) begin errors++; $display("FAIL order_early_commit got %0d want 0", commit_reg); end
    cdb_tag = 4'd1; cdb_value = 32'd9; tick();
    cdb_valid = 0; tick();
    checks++; if (commit_reg !== 5'd3 || commit_tag !== 4'd1 || commit_value !== 32'd9) begin
      errors++; $display("FAIL order_first got reg %0d tag %0d val %0d want 3 1 9", commit_reg, commit_tag, commit_value); end
    tick();
    checks++; if (commit_reg !== 5'd4 || commit_tag !== 4'd2 || commit_value !== 32'd7) begin
      errors++; $display("FAIL order_second got reg %0d tag %0d val %0d want 4 2 7", commit_reg, commit_tag, commit_value); end
    tick();
    checks++; if (commit_reg !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL order_drain got reg %0d empty %b want 0 1", commit_reg, empty); end
    $display("test_in_order done");
  endtask

  // Leaves the buffer full with tag 1 reallocated, for test_query.
  task automatic test_full();
    do_reset();
    alloc_ena = 1;
    for (int i = 0; i < 15; i++) begin alloc_rd = 5'(i + 1); tick(); end
    checks++; if (full !== 1'b1 || alloc_tag !== 4'd1) begin
      errors++; $display("FAIL full_after15 got full %b tag %0d want 1 1", full, alloc_tag); end
    alloc_rd = 5'd30; tick();
    checks++; if (full !== 1'b1 || alloc_tag !== 4'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL full_ignore got full %b tag %0d empty %b want 1 1 0", full, alloc_tag, empty); end
    alloc_ena = 0; cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'h11; tick();
    cdb_valid = 0; alloc_ena = 1; alloc_rd = 5'd31; tick();
    checks++; if (commit_reg !== 5'd1 || commit_tag !== 4'd1 || commit_value !== 32'h11) begin
      errors++; $display("FAIL full_commit got reg %0d tag %0d val %h want 1 1 11", commit_reg, commit_tag, commit_value); end
    checks++; if (full !== 1'b0 || alloc_tag !== 4'd1) begin
      errors++; $display("FAIL full_same_cycle_alloc got full %b tag %0d want 0 1", full, alloc_tag); end
    alloc_rd = 5'd9; tick();
    alloc_ena = 0;
    checks++; if (full !== 1'b1 || alloc_tag !== 4'd2) begin
      errors++; $display("FAIL full_realloc got full %b tag %0d want 1 2", full, alloc_tag); end
    $display("test_full done");
  endtask

  task automatic test_query();
    cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'h42; query_tag1 = 4'd3; query_tag2 = 4'd0; #1;
    checks++; if (query_ready1 !== 1'b1 || query_value1 !== 32'h42) begin
      errors++; $display("FAIL query_bypass got %b %h want 1 42", query_ready1, query_value1); end
    checks++; if (query_ready2 !== 1'b0 || query_value2 !== 32'h0) begin
      errors++; $display("FAIL query_zero got %b %h want 0 0", query_ready2, query_value2); end
    tick();
    cdb_valid = 0; query_tag2 = 4'd4; #1;
    checks++; if (query_ready1 !== 1'b1 || query_value1 !== 32'h42) begin
      errors++; $display("FAIL query_stored got %b %h want 1 42", query_ready1, query_value1); end
    checks++; if (query_ready2 !== 1'b0) begin
      errors++; $display("FAIL query_pending got %b want 0", query_ready2); end
    query_tag1 = '0; query_tag2 = '0;
    $display("test_query done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_ena = 1;
    for (int i = 0; i < 4; i++) begin alloc_rd = 5'(i + 1); tick(); end
    alloc_ena = 0; cdb_valid = 1;
    cdb_tag = 4'd2; cdb_value = 32'h22; tick();
    cdb_tag = 4'd3; cdb_value = 32'h33; tick();
    cdb_valid = 0; rst = 1; tick(); rst = 0;
    checks++; if (empty !== 1'b1 || commit_reg !== 5'd0 || alloc_tag !== 4'd1) begin
      errors++; $display("FAIL rstmid got empty %b reg %0d tag %0d want 1 0 1", empty, commit_reg, alloc_tag); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_reg !== 5'd0) begin errors++; $display("FAIL rstmid_no_commit got %0d want 0", commit_reg); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_ena_hold();
    do_reset();
    alloc_ena = 1; alloc_rd = 5'd7; tick();
    alloc_ena = 0; cdb_valid = 1; cdb_tag = 4'd1; cdb_value = 32'h55; tick();
    cdb_valid = 0; ena = 0; alloc_ena = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_reg !== 5'd0 || empty !== 1'b0 || alloc_tag !== 4'd2) begin
        errors++; $display("FAIL ena_frozen got reg %0d empty %b tag %0d want 0 0 2", commit_reg, empty, alloc_tag); end
    end
    ena = 1; alloc_ena = 0; tick();
    checks++; if (commit_reg !== 5'd7 || commit_value !== 32'h55 || empty !== 1'b1) begin
      errors++; $display("FAIL ena_resume got reg %0d val %h empty %b want 7 55 1", commit_reg, commit_value, empty); end
    ena = 0; tick();
    checks++; if (commit_reg !== 5'd7) begin errors++; $display("FAIL ena_hold_reg got %0d want 7", commit_reg); end
    ena = 1;
    $display("test_ena_hold done");
  endtask

  task automatic test_random();
    bit          er1, er2;
    logic [31:0] ev1, ev2;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst       = ($urandom_range(0, 149) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      alloc_ena = ($urandom_range(0, 1) == 1);
      alloc_rd  = 5'($urandom_range(0, 31));
      cdb_valid = ($urandom_range(0, 9) < 6);
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
        cdb_tag = 4'(m_q[$urandom_range(0, m_q.size() - 1)]);
      else
        cdb_tag = 4'($urandom_range(0, 15));
      cdb_value  = $urandom;
      query_tag1 = 4'($urandom_range(0, 15));
      query_tag2 = ($urandom_range(0, 1) == 1) ? cdb_tag : 4'($urandom_range(0, 15));
      #1;
      er1 = (query_tag1 == 0) ? 1'b0 : (cdb_valid && cdb_tag == query_tag1) ? 1'b1 : m_ready[query_tag1];
      ev1 = (query_tag1 == 0) ? 32'd0 : (cdb_valid && cdb_tag == query_tag1) ? cdb_value : m_val[query_tag1];
      er2 = (query_tag2 == 0) ? 1'b0 : (cdb_valid && cdb_tag == query_tag2) ? 1'b1 : m_ready[query_tag2];
      ev2 = (query_tag2 == 0) ? 32'd0 : (cdb_valid && cdb_tag == query_tag2) ? cdb_value : m_val[query_tag2];
      checks++; if (full !== (m_q.size() == 15) || empty !== (m_q.size() == 0) || alloc_tag !== 4'(m_tail)) begin
        errors++; $display("FAIL rand_flags cyc %0d got full %b empty %b tag %0d want %b %b %0d",
                           cyc, full, empty, alloc_tag, m_q.size() == 15, m_q.size() == 0, m_tail); end
      checks++; if (query_ready1 !== er1 || (er1 && query_value1 !== ev1)) begin
        errors++; $display("FAIL rand_query1 cyc %0d got %b %h want %b %h", cyc, query_ready1, query_value1, er1, ev1); end
      checks++; if (query_ready2 !== er2 || (er2 && query_value2 !== ev2)) begin
        errors++; $display("FAIL rand_query2 cyc %0d got %b %h want %b %h", cyc, query_ready2, query_value2, er2, ev2); end
      tick();
      checks++; if (commit_reg !== 5'(e_creg) || commit_tag !== 4'(e_ctag) || commit_value !== e_cval) begin
        errors++; $display("FAIL rand_commit cyc %0d got reg %0d tag %0d val %h want %0d %0d %h",
                           cyc, commit_reg, commit_tag, commit_value, e_creg, e_ctag, e_cval); end
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1;
    test_reset();
    test_single();
    test_in_order();
    test_full();
    test_query();
    test_reset_mid();
    test_ena_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
